// File: rtl/mem_pkg.sv
// mem_pkg: shared states, transfer sizes and size decode for the memory sequencer
package mem_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;
  // Illegal sizes fall back to a full word.
  function automatic logic [2:0] size_to_beats(input logic [2:0] size);
    return (size == SZ_B || size == SZ_H) ? size : SZ_W;
  endfunction
endpackage

// File: rtl/mem_sequencer_load_ext.sv
// load_ext: assembles the byte-lane register into a sign- or zero-extended word
module load_ext import mem_pkg::*; (
  input  logic [31:0] lanes,
  input  logic [2:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [2:0] n;
  logic       fill;
  // Fill the bytes above the access size with the top received byte's sign or zero.
  always_comb begin
    n = size_to_beats(size);
    fill = sgn & (n == SZ_B ? lanes[7] : n == SZ_H ? lanes[15] : lanes[31]);
    data = n == SZ_B ? {{24{fill}}, lanes[7:0]} : n == SZ_H ? {{16{fill}}, lanes[15:0]} : lanes;
  end
endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: splits loads/stores into little-endian byte beats over a req/ack bus
module mem_sequencer import mem_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        xfer_size,
  input  logic              load_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  state_t            state;
  logic [ADDR_W-1:0] a;
  logic [31:0]       wd, lanes, lanes_nx, ext;
  logic [2:0]        size;
  logic              sgn, we, op, last, tmo;
  logic [1:0]        beat;
  logic [WW-1:0]     wcnt;
  load_ext u_ext (.lanes(lanes_nx), .size(size), .sgn(sgn), .data(ext));
  // Bus drive and pipeline stall derived from the current beat; stall must see a new op immediately.
  always_comb begin
    op = start && (mem_read || mem_write);
    stall = (state == IDLE && op) || state == XFER;
    bus_req = state == XFER;
    bus_we = state == XFER && we;
    bus_addr = a + ADDR_W'(beat);
    bus_wdata = wd[8*beat +: 8];
    lanes_nx = lanes;
    lanes_nx[8*beat +: 8] = bus_rdata;
    last = {1'b0, beat} == size_to_beats(size) - 3'd1;
    tmo = TIMEOUT != 0 && wcnt == WW'(TIMEOUT - 1);
  end
  // Access FSM: latch the op, step beats on ack, abort on timeout, pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      wd <= '0;
      lanes <= '0;
      size <= '0;
      sgn <= 1'b0;
      we <= 1'b0;
      beat <= '0;
      wcnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (op) begin
          state <= XFER;
          a <= addr;
          wd <= wdata;
          size <= xfer_size;
          sgn <= load_signed;
          we <= mem_write;
          beat <= '0;
          wcnt <= '0;
          lanes <= '0;
          rdata <= '0;
        end
        XFER: if (bus_ack) begin
          lanes <= lanes_nx;
          beat <= beat + 2'd1;
          wcnt <= '0;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            rdata <= we ? '0 : ext;
          end
        end else if (tmo) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b1;
          rdata <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: cycle-timeline model of the sequencer checked against the DUT every cycle
module tb_mem_sequencer;
  localparam int TMO = 4;
  localparam int N = 1024;
  logic clk = 0, rst_n = 0, start = 0, mem_read = 0, mem_write = 0, load_signed = 0, bus_ack = 0;
  logic [2:0] xfer_size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [7:0] bus_rdata = 0;
  logic stall, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr;
  logic [7:0] bus_wdata;
  int cyc = 0, checks = 0, errors = 0;
  logic e_on[N], e_stall[N], e_req[N], e_done[N], e_err[N], e_bus[N], e_rdon[N], e_we[N];
  logic [31:0] e_addr[N], e_rd[N];
  logic [7:0] e_wd[N];

  mem_sequencer #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .xfer_size(xfer_size), .load_signed(load_signed), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (cyc < N && e_on[cyc]) begin
    chk("stall", 32'(stall), 32'(e_stall[cyc]));
    chk("bus_req", 32'(bus_req), 32'(e_req[cyc]));
    chk("done", 32'(done), 32'(e_done[cyc]));
    chk("err", 32'(err), 32'(e_err[cyc]));
    if (e_bus[cyc]) begin
      chk("bus_addr", bus_addr, e_addr[cyc]);
      chk("bus_we", 32'(bus_we), 32'(e_we[cyc]));
      chk("bus_wdata", 32'(bus_wdata), 32'(e_wd[cyc]));
    end
    if (e_rdon[cyc]) chk("rdata", rdata, e_rd[cyc]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp(input int c);
    e_on[c] = 1; e_stall[c] = 0; e_req[c] = 0; e_done[c] = 0; e_err[c] = 0; e_bus[c] = 0; e_rdon[c] = 0;
  endtask

  // waits holds one byte per beat: idle cycles before that beat's ack (>= TMO means never acked).
  task automatic do_op(input logic rd, input logic wr, input logic sg, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] bytes,
                       input logic [31:0] waits, output int dc);
    int c, nb, w, n;
    logic [31:0] v;
    logic to;
    c = cyc; nb = (sz == 1 || sz == 2) ? int'(sz) : 4; to = 0; v = 0;
    idle_exp(c); e_stall[c] = 1;
    start = 1; mem_read = rd; mem_write = wr; xfer_size = sz; load_signed = sg;
    addr = ad; wdata = wd; bus_ack = 1; bus_rdata = 8'hEE;
    tick();
    start = 0; mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
    for (int k = 0; k < nb && !to; k++) begin
      w = int'(waits[8*k +: 8]);
      to = w >= TMO;
      n = to ? TMO : w + 1;
      for (int j = 0; j < n; j++) begin
        idle_exp(cyc); e_stall[cyc] = 1; e_req[cyc] = 1; e_bus[cyc] = 1;
        e_addr[cyc] = ad + 32'(k); e_we[cyc] = wr; e_wd[cyc] = wd[8*k +: 8];
        bus_ack = !to && j == n - 1;
        bus_rdata = bus_ack ? bytes[8*k +: 8] : 8'($urandom);
        tick();
      end
      v[8*k +: 8] = bytes[8*k +: 8];
    end
    if (to || wr) v = 0;
    else if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
    dc = cyc;
    idle_exp(cyc); e_done[cyc] = 1; e_err[cyc] = to; e_rdon[cyc] = 1; e_rd[cyc] = v;
    start = 1; mem_read = 1; xfer_size = 3'd4; bus_ack = 1; bus_rdata = 8'h77;
    tick();
    idle_exp(cyc); e_rdon[cyc] = 1; e_rd[cyc] = v;
    start = 0; mem_read = 0; bus_ack = 0;
    tick();
  endtask

  initial begin
    int c, dc;
    for (int i = 0; i < N; i++) e_on[i] = 0;
    tick();
    idle_exp(cyc); e_bus[cyc] = 1; e_addr[cyc] = 0; e_we[cyc] = 0; e_wd[cyc] = 0; e_rdon[cyc] = 1; e_rd[cyc] = 0;
    tick();
    rst_n = 1;
    idle_exp(cyc); e_rdon[cyc] = 1; e_rd[cyc] = 0;
    tick();
    c = cyc; do_op(1, 0, 0, 3'd4, 32'h100, 32'h0, 32'h44332211, 32'h0, dc);
    chk("lw_latency", 32'(dc - c), 32'd5);
    chk("lw_rdata_lit", rdata, 32'h44332211);
    c = cyc; do_op(1, 0, 1, 3'd1, 32'h7, 32'h0, 32'h80, 32'h0, dc);
    chk("lb_latency", 32'(dc - c), 32'd2);
    chk("lb_rdata_lit", rdata, 32'hFFFFFF80);
    do_op(1, 0, 0, 3'd1, 32'h7, 32'h0, 32'h80, 32'h0, dc);
    chk("lbu_rdata_lit", rdata, 32'h00000080);
    c = cyc; do_op(0, 1, 0, 3'd2, 32'h203, 32'hABCD1234, 32'h0, 32'h0, dc);
    chk("sh_latency", 32'(dc - c), 32'd3);
    do_op(0, 1, 0, 3'd2, 32'hFFFFFFFF, 32'hABCD1234, 32'h0, 32'h0, dc);
    c = cyc; do_op(1, 0, 1, 3'd2, 32'h50, 32'h0, 32'h8001, 32'h0303, dc);
    chk("lh_wait_latency", 32'(dc - c), 32'd9);
    chk("lh_rdata_lit", rdata, 32'hFFFF8001);
    c = cyc; do_op(1, 0, 0, 3'd4, 32'h300, 32'h0, 32'h0, 32'hFFFFFFFF, dc);
    chk("timeout_latency", 32'(dc - c), 32'd5);
    do_op(1, 0, 0, 3'd4, 32'h304, 32'h0, 32'hDEADBEEF, 32'h00020100, dc);
    do_op(1, 0, 1, 3'd3, 32'hFFFFFFFE, 32'h0, 32'h89ABCDEF, 32'h01000000, dc);
    do_op(1, 0, 1, 3'd0, 32'h10, 32'h0, 32'hF0E0D0C0, 32'h0, dc);
    do_op(1, 1, 1, 3'd2, 32'h20, 32'h5566A7B8, 32'hFFFF, 32'h0001, dc);
    do_op(0, 1, 0, 3'd7, 32'h31, 32'hCAFEF00D, 32'h0, 32'h03000200, dc);
    do_op(1, 0, 0, 3'd2, 32'h41, 32'h0, 32'hFF7F, 32'h0, dc);
    chk("lhu_rdata_lit", rdata, 32'h0000FF7F);
    idle_exp(cyc); start = 1; mem_read = 0; mem_write = 0; bus_ack = 1;
    tick();
    idle_exp(cyc); start = 0; bus_ack = 0;
    tick();
    c = cyc; start = 1; mem_read = 1; xfer_size = 3'd4; addr = 32'h40; wdata = 0;
    idle_exp(c); e_stall[c] = 1;
    tick();
    start = 0; mem_read = 0; bus_ack = 1; bus_rdata = 8'h5A;
    idle_exp(cyc); e_stall[cyc] = 1; e_req[cyc] = 1; e_bus[cyc] = 1; e_addr[cyc] = 32'h40; e_we[cyc] = 0; e_wd[cyc] = 0;
    tick();
    bus_ack = 0; rst_n = 0;
    idle_exp(cyc); e_stall[cyc] = 1; e_req[cyc] = 1; e_bus[cyc] = 1; e_addr[cyc] = 32'h41; e_we[cyc] = 0; e_wd[cyc] = 0;
    tick();
    rst_n = 1;
    idle_exp(cyc); e_bus[cyc] = 1; e_addr[cyc] = 0; e_we[cyc] = 0; e_wd[cyc] = 0; e_rdon[cyc] = 1; e_rd[cyc] = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_exp(cyc);
      tick();
    end
    do_op(1, 0, 1, 3'd1, 32'h9, 32'h0, 32'h7F, 32'h02, dc);
    chk("lb_pos_lit", rdata, 32'h0000007F);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
